alu_cmd_ctrl: RTL and testbench

Command-side controller that drives the ALU's `op1`/`op2`/`alu_op` inputs and consumes its `result`/`zero`/`ovf` outputs. It accepts 4-bit function commands over a valid/ready handshake and decodes them to the ALU operation encoding. It holds an accumulator as the left operand and returns each result over a second valid/ready handshake. It sits between the command source (testbench/front-end FSM) and the combinational ALU, and is the only writer of the ALU operand ports.

---
 rtl/alu_cmd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command-side controller for a combinational ALU.
// Accepts 4-bit function commands over a valid/ready handshake and keeps an
// accumulator as the ALU left operand. Each ALU input is driven from a flop.
// The ALU result is captured one cycle after accept. The response is then
// returned over a second valid/ready handshake.
// Optional feature: define ALU_CMD_CTRL_SAT_EN to saturate ADD/SUB on overflow.
module alu_cmd_ctrl #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [3:0]      cmd_func_i,
    input  logic [SIZE-1:0] cmd_operand_i,
    output logic [SIZE-1:0] alu_op1_o,
    output logic [SIZE-1:0] alu_op2_o,
    output logic [3:0]      alu_opc_o,
    input  logic [SIZE-1:0] alu_result_i,
    input  logic            alu_zero_i,
    input  logic            alu_ovf_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [SIZE-1:0] rsp_data_o,
    output logic            rsp_zero_o,
    output logic            rsp_ovf_o,
    output logic            rsp_err_o,
    output logic            sticky_ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] FUNC_ADD   = 4'd5;
    localparam logic [3:0] FUNC_SUB   = 4'd6;
    localparam logic [3:0] FUNC_LOAD  = 4'd12;
    localparam logic [3:0] FUNC_CLEAR = 4'd13;
    localparam logic [3:0] OPC_RESET  = 4'b0100;

    localparam logic [SIZE-1:0] SAT_POS = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic [SIZE-1:0] SAT_NEG = {1'b1, {(SIZE-1){1'b0}}};

    state_t          state_q, state_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [SIZE-1:0] op1_q, op1_d;
    logic [SIZE-1:0] op2_q, op2_d;
    logic [3:0]      opc_q, opc_d;
    logic [3:0]      func_q, func_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic            rsp_err_q, rsp_err_d;
    logic            sticky_q, sticky_d;

    // Map the command function code onto the ALU operation encoding.
    // Non-ALU codes (LOAD, CLEAR, illegal) park the ALU on ADD.
    function automatic logic [3:0] decode_func(input logic [3:0] f);
        logic [3:0] opc;
        case (f)
            4'd0:    opc = 4'b1000;
            4'd1:    opc = 4'b1001;
            4'd2:    opc = 4'b1010;
            4'd3:    opc = 4'b1011;
            4'd4:    opc = 4'b1100;
            4'd5:    opc = 4'b0100;
            4'd6:    opc = 4'b0101;
            4'd7:    opc = 4'b0110;
            4'd8:    opc = 4'b0000;
            4'd9:    opc = 4'b0001;
            4'd10:   opc = 4'b0010;
            4'd11:   opc = 4'b0011;
            default: opc = OPC_RESET;
        endcase
        return opc;
    endfunction

    // Next-state and register-update logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        func_d      = func_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;
        sticky_d    = sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d     = ST_EXEC;
                    op1_d       = acc_q;
                    op2_d       = cmd_operand_i;
                    opc_d       = decode_func(cmd_func_i);
                    func_d      = cmd_func_i;
                    cmd_ready_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                case (func_q)
                    FUNC_LOAD: begin
                        acc_d      = op2_q;
                        rsp_zero_d = (op2_q == {SIZE{1'b0}});
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b0;
                    end
                    FUNC_CLEAR: begin
                        acc_d      = {SIZE{1'b0}};
                        rsp_zero_d = 1'b1;
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b0;
                        sticky_d   = 1'b0;
                    end
                    4'd14, 4'd15: begin
                        acc_d      = acc_q;
                        rsp_zero_d = (acc_q == {SIZE{1'b0}});
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                    end
                    default: begin
                        acc_d      = alu_result_i;
                        rsp_zero_d = alu_zero_i;
                        rsp_ovf_d  = alu_ovf_i;
                        rsp_err_d  = 1'b0;
                        sticky_d   = sticky_q | alu_ovf_i;
`ifdef ALU_CMD_CTRL_SAT_EN
                        // Clamp toward the sign of the left operand; the
                        // clamped value is never zero.
                        if (alu_ovf_i && ((func_q == FUNC_ADD) || (func_q == FUNC_SUB))) begin
                            acc_d      = op1_q[SIZE-1] ? SAT_NEG : SAT_POS;
                            rsp_zero_d = 1'b0;
                        end else begin
                            acc_d      = alu_result_i;
                            rsp_zero_d = alu_zero_i;
                        end
`endif
                    end
                endcase
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= {SIZE{1'b0}};
            op1_q       <= {SIZE{1'b0}};
            op2_q       <= {SIZE{1'b0}};
            opc_q       <= OPC_RESET;
            func_q      <= 4'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            func_q      <= func_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign alu_op1_o    = op1_q;
    assign alu_op2_o    = op2_q;
    assign alu_opc_o    = opc_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = acc_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_ovf_o    = rsp_ovf_q;
    assign rsp_err_o    = rsp_err_q;
    assign sticky_ovf_o = sticky_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: behavioural ALU plus accumulator
// reference model, directed scenarios followed by randomized commands.
module tb_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_func;
    logic [31:0] cmd_operand;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_opc;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        sticky_ovf;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] acc_m;
    logic        sticky_m;

    localparam logic [3:0] OPC_TAB [12] = '{
        4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b0100,
        4'b0101, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0011
    };

    always #5 clk = ~clk;

    alu_cmd_ctrl #(.SIZE(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_func_i   (cmd_func),
        .cmd_operand_i(cmd_operand),
        .alu_op1_o    (alu_op1),
        .alu_op2_o    (alu_op2),
        .alu_opc_o    (alu_opc),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .alu_ovf_i    (alu_ovf),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_zero_o   (rsp_zero),
        .rsp_ovf_o    (rsp_ovf),
        .rsp_err_o    (rsp_err),
        .sticky_ovf_o (sticky_ovf)
    );

    // Behavioural combinational ALU driven by the controller's operand flops.
    always_comb begin
        alu_result = 32'd0;
        alu_ovf    = 1'b0;
        case (alu_opc)
            4'b1000: alu_result = alu_op1 & alu_op2;
            4'b1001: alu_result = alu_op1 | alu_op2;
            4'b1010: alu_result = ~(alu_op1 | alu_op2);
            4'b1011: alu_result = ~(alu_op1 & alu_op2);
            4'b1100: alu_result = alu_op1 ^ alu_op2;
            4'b0100: begin
                alu_result = alu_op1 + alu_op2;
                alu_ovf = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
            end
            4'b0101: begin
                alu_result = alu_op1 - alu_op2;
                alu_ovf = (alu_op1[31] != alu_op2[31]) && (alu_result[31] != alu_op1[31]);
            end
            4'b0110: alu_result = alu_op1 * alu_op2;
            4'b0000: alu_result = alu_op1 >> alu_op2[4:0];
            4'b0001: alu_result = alu_op1 << alu_op2[4:0];
            4'b0010: alu_result = $signed(alu_op1) >>> alu_op2[4:0];
            4'b0011: alu_result = alu_op1 << alu_op2[4:0];
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: new accumulator and flags from the command semantics.
    task automatic model(input logic [3:0] f, input logic [31:0] b,
                         output logic [31:0] nacc, output logic ezero,
                         output logic eovf, output logic eerr);
        longint sa, sb, wide;
        sa = longint'($signed(acc_m));
        sb = longint'($signed(b));
        eovf = 1'b0;
        eerr = 1'b0;
        nacc = acc_m;
        case (f)
            4'd0:  nacc = acc_m & b;
            4'd1:  nacc = acc_m | b;
            4'd2:  nacc = ~(acc_m | b);
            4'd3:  nacc = ~(acc_m & b);
            4'd4:  nacc = acc_m ^ b;
            4'd5, 4'd6: begin
                wide = (f == 4'd5) ? sa + sb : sa - sb;
                nacc = wide[31:0];
                eovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`ifdef ALU_CMD_CTRL_SAT_EN
                if (eovf) nacc = (wide > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            end
            4'd7:  nacc = acc_m * b;
            4'd8:  nacc = acc_m / (32'd1 << b[4:0]);
            4'd9, 4'd11: nacc = acc_m * (32'd1 << b[4:0]);
            4'd10: begin
                wide = sa >>> b[4:0];
                nacc = wide[31:0];
            end
            4'd12: nacc = b;
            4'd13: nacc = 32'd0;
            default: eerr = 1'b1;
        endcase
        ezero = (nacc == 32'd0);
    endtask

    // One full command: accept, EXEC, response held 'hold' cycles, handshake.
    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic run_cmd(input logic [3:0] f, input logic [31:0] b, input int hold, input bit poke);
        logic [31:0] nacc;
        logic ez, eo, ee;
        logic [31:0] prev_acc;
        prev_acc = acc_m;
        model(f, b, nacc, ez, eo, ee);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_func = f; cmd_operand = b; rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_func = 4'($urandom); cmd_operand = $urandom;
        check("exec_cmd_ready", cmd_ready, 0);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_op1", alu_op1, prev_acc);
        check("exec_op2", alu_op2, b);
        if (f < 4'd12) check("exec_opc", alu_opc, OPC_TAB[f]);
        acc_m = nacc;
        if (f == 4'd13) sticky_m = 1'b0;
        if (eo) sticky_m = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, acc_m);
        check("rsp_zero", rsp_zero, ez);
        check("rsp_ovf", rsp_ovf, eo);
        check("rsp_err", rsp_err, ee);
        check("sticky_ovf", sticky_ovf, sticky_m);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1; cmd_func = 4'd12; cmd_operand = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, acc_m);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_rsp_data", rsp_data, acc_m);
    endtask

    initial begin
        logic [3:0]  rf;
        logic [31:0] rb;
        rst = 1'b1; cmd_valid = 1'b0; cmd_func = 4'd0; cmd_operand = 32'd0; rsp_ready = 1'b0;
        acc_m = 32'd0; sticky_m = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_op1", alu_op1, 0);
        check("rst_op2", alu_op2, 0);
        check("rst_opc", alu_opc, 4'b0100);
        check("rst_flags", {rsp_zero, rsp_ovf, rsp_err, sticky_ovf}, 4'b0000);

        // Directed scenarios.
        run_cmd(4'd12, 32'd5, 0, 1'b0);
        check("load5", rsp_data, 32'd5);
        run_cmd(4'd5, 32'd7, 0, 1'b0);
        check("add7", rsp_data, 32'd12);
        run_cmd(4'd12, 32'h7FFF_FFFF, 0, 1'b0);
        run_cmd(4'd5, 32'd1, 0, 1'b0);
`ifdef ALU_CMD_CTRL_SAT_EN
        check("ovf_sat_data", rsp_data, 32'h7FFF_FFFF);
`else
        check("ovf_wrap_data", rsp_data, 32'h8000_0000);
`endif
        check("ovf_sticky", sticky_ovf, 1);
        run_cmd(4'd12, 32'd3, 0, 1'b0);
        run_cmd(4'd6, 32'd3, 1, 1'b0);
        check("sub_zero", {rsp_zero, rsp_data}, {1'b1, 32'd0});
        run_cmd(4'd13, 32'd77, 0, 1'b0);
        check("clear_sticky", {sticky_ovf, rsp_zero}, 2'b01);
        run_cmd(4'd12, 32'd9, 0, 1'b0);
        run_cmd(4'd14, 32'd4, 2, 1'b0);
        check("illegal", {rsp_err, rsp_data}, {1'b1, 32'd9});
        run_cmd(4'd5, 32'd1, 0, 1'b0);
        check("after_illegal", {rsp_err, rsp_data}, {1'b0, 32'd10});
        run_cmd(4'd12, 32'd7, 0, 1'b0);
        run_cmd(4'd7, 32'd6, 5, 1'b1);
        check("mul42", rsp_data, 32'd42);

        // Reset while in EXEC aborts the ADD.
        cmd_valid = 1'b1; cmd_func = 4'd5; cmd_operand = 32'd1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        acc_m = 32'd0; sticky_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstx_rsp_valid", rsp_valid, 0);
        check("rstx_cmd_ready", cmd_ready, 1);
        check("rstx_rsp_data", rsp_data, 0);
        check("rstx_opc", alu_opc, 4'b0100);
        check("rstx_sticky", sticky_ovf, 0);

        // Randomized command stream with idle gaps.
        for (int n = 0; n < 80; n++) begin
            rf = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 40));
                1:       rb = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            run_cmd(rf, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                check("gap_rsp_valid", rsp_valid, 0);
                check("gap_cmd_ready", cmd_ready, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
